// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: converts ASCII key events into PS/2 scan-code set 2 frames.
// A make event sends one frame with the scan code. A break event sends F0,
// then an inter-byte gap, then the scan code. Every frame is followed by a
// gap with both lines released high.
`timescale 1ns/1ps
module ps2_kbd_tx #(
  parameter int CLK_DIV  = 50,
  parameter int BYTE_GAP = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_ascii,
  input  logic       key_release,
  output logic       key_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       err_unmapped
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // 17 bits holds any terminal count up to 65535 without wrapping
  localparam logic [16:0] HALF_LAST = 17'(CLK_DIV - 1);
  localparam logic [16:0] GAP_LAST  = 17'(BYTE_GAP - 1);
  localparam logic [7:0]  BREAK_PREFIX = 8'hF0;

  state_t      r_state;
  state_t      w_nextState;
  logic [16:0] r_cnt;
  logic        r_half;
  logic [3:0]  r_bitIdx;
  logic [7:0]  r_byte;
  logic [7:0]  r_code;
  logic        r_pending;
  logic        r_err;

  logic [8:0]  w_map;
  logic        w_mapped;
  logic [7:0]  w_scan;
  logic        w_accept;
  logic        w_halfEnd;
  logic        w_frameEnd;
  logic        w_gapEnd;
  logic        w_bitVal;

  // ASCII to scan code set 2; bit 8 flags a valid mapping
  function automatic logic [8:0] mapAscii(input logic [7:0] a);
    logic [8:0] m;
    m = 9'h000;
    case (a)
      8'h31: m = 9'h116;  8'h32: m = 9'h11E;  8'h33: m = 9'h126;
      8'h34: m = 9'h125;  8'h35: m = 9'h12E;  8'h36: m = 9'h136;
      8'h37: m = 9'h13D;  8'h38: m = 9'h13E;  8'h39: m = 9'h146;
      8'h30: m = 9'h145;
      8'h61: m = 9'h11C;  8'h62: m = 9'h132;  8'h63: m = 9'h121;
      8'h64: m = 9'h123;  8'h65: m = 9'h124;  8'h66: m = 9'h12B;
      8'h67: m = 9'h134;  8'h68: m = 9'h133;  8'h69: m = 9'h143;
      8'h6A: m = 9'h13B;  8'h6B: m = 9'h142;  8'h6C: m = 9'h14B;
      8'h6D: m = 9'h13A;  8'h6E: m = 9'h131;  8'h6F: m = 9'h144;
      8'h70: m = 9'h14D;  8'h71: m = 9'h115;  8'h72: m = 9'h12D;
      8'h73: m = 9'h11B;  8'h74: m = 9'h12C;  8'h75: m = 9'h13C;
      8'h76: m = 9'h12A;  8'h77: m = 9'h11D;  8'h78: m = 9'h122;
      8'h79: m = 9'h135;  8'h7A: m = 9'h11A;
      default: m = 9'h000;
    endcase
    return m;
  endfunction

  assign w_map        = mapAscii(key_ascii);
  assign w_mapped     = w_map[8];
  assign w_scan       = w_map[7:0];
  assign w_accept     = key_valid && (r_state == IDLE);
  assign w_halfEnd    = (r_state == SEND) && (r_cnt == HALF_LAST);
  assign w_frameEnd   = w_halfEnd && r_half && (r_bitIdx == 4'd10);
  assign w_gapEnd     = (r_state == GAP) && (r_cnt == GAP_LAST);
  assign err_unmapped = r_err;

  // Selects the line level for the current bit slot: start, LSB-first data, odd parity, stop
  always_comb begin
    w_bitVal = 1'b1;
    case (r_bitIdx)
      4'd0:    w_bitVal = 1'b0;
      4'd1:    w_bitVal = r_byte[0];
      4'd2:    w_bitVal = r_byte[1];
      4'd3:    w_bitVal = r_byte[2];
      4'd4:    w_bitVal = r_byte[3];
      4'd5:    w_bitVal = r_byte[4];
      4'd6:    w_bitVal = r_byte[5];
      4'd7:    w_bitVal = r_byte[6];
      4'd8:    w_bitVal = r_byte[7];
      4'd9:    w_bitVal = ~^r_byte;
      default: w_bitVal = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and line/handshake outputs; lines idle high outside SEND
  always_comb begin
    w_nextState = r_state;
    key_ready   = 1'b0;
    busy        = 1'b1;
    ps2_clk     = 1'b1;
    ps2_data    = 1'b1;
    case (r_state)
      IDLE: begin
        key_ready = 1'b1;
        busy      = 1'b0;
        if (w_accept && w_mapped) begin
          w_nextState = SEND;
        end
      end
      SEND: begin
        ps2_clk  = ~r_half;
        ps2_data = w_bitVal;
        if (w_frameEnd) begin
          w_nextState = GAP;
        end
      end
      GAP: begin
        if (w_gapEnd) begin
          w_nextState = r_pending ? SEND : IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: latches the event, walks half-periods and bit slots, times the gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_half    <= 1'b0;
      r_bitIdx  <= '0;
      r_byte    <= '0;
      r_code    <= '0;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_accept && !w_mapped;
      case (r_state)
        IDLE: begin
          r_cnt    <= '0;
          r_half   <= 1'b0;
          r_bitIdx <= '0;
          if (w_accept && w_mapped) begin
            r_code    <= w_scan;
            r_pending <= key_release;
            r_byte    <= key_release ? BREAK_PREFIX : w_scan;
          end
        end
        SEND: begin
          if (w_halfEnd) begin
            r_cnt  <= '0;
            r_half <= ~r_half;
            if (r_half) begin
              r_bitIdx <= (r_bitIdx == 4'd10) ? 4'd0 : r_bitIdx + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + 17'd1;
          end
        end
        GAP: begin
          if (w_gapEnd) begin
            r_cnt    <= '0;
            r_half   <= 1'b0;
            r_bitIdx <= '0;
            if (r_pending) begin
              r_byte    <= r_code;
              r_pending <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 17'd1;
          end
        end
        default: begin
          r_cnt    <= '0;
          r_half   <= 1'b0;
          r_bitIdx <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/ps2_kbd_tx.md
PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50, giving the number of clk cycles in each half-period of ps2_clk.
REQ-002 The block SHALL have parameter BYTE_GAP, default 100, giving the number of idle clk cycles after each frame.
REQ-003 Port clk: input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-005 Port key_valid: input, 1 bit, a key event is offered.
REQ-006 Port key_ascii: input, 8 bits, ASCII code of the key (lower-case 'a'-'z', '0'-'9').
REQ-007 Port key_release: input, 1 bit; 1 means a break (release) event, 0 means a make (press) event.
REQ-008 Port key_ready: output, 1 bit, the block can accept an event this cycle.
REQ-009 Port ps2_clk: output, 1 bit, PS/2 clock line driven by the device side.
REQ-010 Port ps2_data: output, 1 bit, PS/2 data line driven by the device side.
REQ-011 Port busy: output, 1 bit, a sequence is being transmitted.
REQ-012 Port err_unmapped: output, 1 bit, one-cycle pulse when an accepted key_ascii has no scan code.

Function
REQ-013 An event SHALL be accepted only in a cycle with key_valid=1 and key_ready=1; key_ready SHALL be 1 only in state IDLE.
REQ-014 key_ascii and key_release SHALL be registered on acceptance; later input changes SHALL NOT affect the sequence in flight.
REQ-015 Mapping SHALL use scan code set 2 as follows:
- '1'-'9' map to 16,1E,26,25,2E,36,3D,3E,46; '0' maps to 45.
- 'a'-'z' map to 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A.
REQ-016 Unmapped ASCII: err_unmapped SHALL be 1 in the cycle after acceptance; nothing is transmitted; the state returns to IDLE in that same cycle.
REQ-017 A make event SHALL send one frame containing the code; a break event SHALL send a frame containing F0, then a BYTE_GAP gap, then a frame containing the code.
REQ-018 The states SHALL be IDLE, SEND and GAP, with these transitions:
- IDLE to SEND on acceptance of a mapped key.
- SEND to GAP after the stop bit completes.
- GAP to SEND if a code byte is pending; otherwise GAP to IDLE after BYTE_GAP cycles.
REQ-019 A frame SHALL be 11 bits sent in this order: start bit 0, data[0] through data[7] (LSB first), odd parity, stop bit 1.
- Parity is set so that the data bits plus the parity bit contain an odd number of ones.
REQ-020 Each bit slot SHALL last 2*CLK_DIV cycles:
- ps2_data changes only at the start of the slot.
- ps2_clk is 1 for the first CLK_DIV cycles and 0 for the second CLK_DIV cycles, so the host samples on the falling edge.
REQ-021 The start-bit slot SHALL begin the cycle after acceptance (ps2_data=0 at that point).
- Total time, acceptance to IDLE, is 22*CLK_DIV+BYTE_GAP+1 cycles for a make event and 2*(22*CLK_DIV+BYTE_GAP)+1 cycles for a break event.
REQ-022 In IDLE and GAP, ps2_clk and ps2_data SHALL both be 1.
REQ-023 busy SHALL equal 1 exactly when the state is not IDLE.
REQ-024 The bit counter and the half-period counter SHALL be wide enough for CLK_DIV and BYTE_GAP values up to 65535 without wrap-around.
REQ-025 key_valid asserted while busy SHALL be ignored (not queued); the event is accepted in the first IDLE cycle in which key_valid is still high.

Reset
REQ-026 While rst=1, the outputs SHALL be as follows, regardless of clk:
- The state is IDLE.
- ps2_clk=1, ps2_data=1.
- key_ready=1, busy=0, err_unmapped=0.
- All counters and the pending-byte flag are cleared.
REQ-027 rst asserted mid-frame SHALL abort the sequence with no partial continuation after release; the first post-reset acceptance starts a fresh frame.

Verification
REQ-028 Make 'a' (key_ascii=61h, key_release=0), CLK_DIV=4:
- Sampled falling-edge bits are 0,0,0,1,1,1,0,0,0,0,1 (code 1C, parity 0).
- busy lasts 88+BYTE_GAP+1 cycles.
REQ-029 Break '1' (key_ascii=31h, key_release=1):
- First frame carries F0 with parity 1.
- BYTE_GAP cycles with both lines high.
- Second frame carries 16 with parity 0.
- Then key_ready=1.
REQ-030 Unmapped '#' (23h): err_unmapped=1 for exactly one cycle; ps2_clk and ps2_data stay 1; key_ready=1 on the following cycle.
REQ-031 Make 'z' is accepted, then key_valid is held high with 'b':
- key_ready stays 0 during the whole 'z' sequence.
- 'b' is accepted in the first IDLE cycle; the second frame carries 32.
REQ-032 rst is pulsed during data bit 4 of a frame: both lines go to 1 immediately, busy=0; a subsequent make '0' sends a complete frame carrying 45 with parity 0.
